// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point adder pipeline.
//   fp32_t        : IEEE-754 single-precision operand, packed {sign, exp, frac}
//   MANT_W/EXP_W  : significand width (with hidden bit) and exponent width
//   EXP_SPECIAL   : exponent value marking Inf/NaN operands
//   BIAS          : exponent bias, used by the normalisation stage downstream
//   align_state_t : state codes of the alignment FSM in fp_align_add
package fp_pkg;

    localparam int MANT_W = 24;
    localparam int EXP_W  = 8;
    localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;
    localparam int BIAS = 127;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [22:0]      frac;
    } fp32_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SWAP  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_ADD   = 3'd3,
        ST_DONE  = 3'd4
    } align_state_t;

endpackage

// File: rtl/fp_unpack.sv
// Combinational unpacker for one single-precision operand.
//   op         in  : packed operand
//   sign       out : operand sign
//   exp        out : biased exponent
//   sig        out : 24-bit significand {hidden, frac}; zero when exp == 0
//   is_special out : exponent is all ones (Inf/NaN)
module fp_unpack
    import fp_pkg::*;
(
    input  fp32_t             op,
    output logic              sign,
    output logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] sig,
    output logic              is_special
);

    assign sign       = op.sign;
    assign exp        = op.exp;
    // Subnormals are flushed to zero, so a zero exponent yields a zero significand.
    assign sig        = (op.exp == '0) ? '0 : {1'b1, op.frac};
    assign is_special = (op.exp == EXP_SPECIAL);

endmodule

// File: rtl/fp_align_add.sv
// Alignment and significand-add stage of the floating-point adder.
//   clk, rst      in  : clock; synchronous active-low reset
//   start         in  : request, sampled only when idle or done
//   a, b          in  : IEEE-754 single operands
//   busy          out : operation in flight
//   done_2        out : result valid (level), held until the next accepted start
//   mantissa_sum  out : {carry, 24-bit magnitude sum/difference}
//   new_exponent  out : larger exponent + 1 (mod 256)
//   sign_out      out : result sign (0 on exact cancellation)
//   zero          out : exact cancellation
//   special       out : either operand had exponent 8'hFF
//
// Handshake: start is accepted on a rising edge where the FSM is IDLE or DONE
// and start=1; that edge captures a/b, raises busy and drops done_2. busy stays
// high until the edge that raises done_2. start while busy is dropped, not queued.
// Results stay stable while done_2=1 and may be sampled on any such cycle.
module fp_align_add
    import fp_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       a,
    input  logic [31:0]       b,
    output logic              busy,
    output logic              done_2,
    output logic [MANT_W:0]   mantissa_sum,
    output logic [EXP_W-1:0]  new_exponent,
    output logic              sign_out,
    output logic              zero,
    output logic              special
);

    localparam logic [2:0] S_IDLE  = ST_IDLE;
    localparam logic [2:0] S_SWAP  = ST_SWAP;
    localparam logic [2:0] S_SHIFT = ST_SHIFT;
    localparam logic [2:0] S_ADD   = ST_ADD;
    localparam logic [2:0] S_DONE  = ST_DONE;

    logic [2:0] state;

    fp32_t op_a, op_b;

    logic              sign_a, sign_b, spec_a, spec_b;
    logic [EXP_W-1:0]  exp_a, exp_b;
    logic [MANT_W-1:0] sig_a, sig_b;

    fp_unpack u_unpack_a (.op(op_a), .sign(sign_a), .exp(exp_a), .sig(sig_a), .is_special(spec_a));
    fp_unpack u_unpack_b (.op(op_b), .sign(sign_b), .exp(exp_b), .sig(sig_b), .is_special(spec_b));

    // Larger/smaller selection from the captured operands.
    logic              l_sign_c, s_sign_c;
    logic [EXP_W-1:0]  l_exp_c, s_exp_c, exp_diff;
    logic [MANT_W-1:0] l_sig_c, s_sig_c;

    always_comb begin
        l_sign_c = sign_a;
        l_exp_c  = exp_a;
        l_sig_c  = sig_a;
        s_sign_c = sign_b;
        s_exp_c  = exp_b;
        s_sig_c  = sig_b;
        // Ordering by {exp, sig} keeps L >= S in magnitude so the subtraction never goes negative.
        if ({exp_a, sig_a} < {exp_b, sig_b}) begin
            l_sign_c = sign_b;
            l_exp_c  = exp_b;
            l_sig_c  = sig_b;
            s_sign_c = sign_a;
            s_exp_c  = exp_a;
            s_sig_c  = sig_a;
        end
    end

    assign exp_diff = l_exp_c - s_exp_c;

    // Aligned operands held across the SHIFT cycles.
    logic              l_sign, s_sign, spec_r;
    logic [EXP_W-1:0]  l_exp;
    logic [MANT_W-1:0] l_sig, s_sig;
    logic [4:0]        cnt;
    logic [MANT_W:0]   sum_c;

    assign sum_c = (l_sign == s_sign) ? ({1'b0, l_sig} + {1'b0, s_sig})
                                      : ({1'b0, l_sig} - {1'b0, s_sig});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_IDLE;
            busy         <= 1'b0;
            done_2       <= 1'b0;
            mantissa_sum <= '0;
            new_exponent <= '0;
            sign_out     <= 1'b0;
            zero         <= 1'b0;
            special      <= 1'b0;
            op_a         <= '0;
            op_b         <= '0;
            l_sign       <= 1'b0;
            s_sign       <= 1'b0;
            spec_r       <= 1'b0;
            l_exp        <= '0;
            l_sig        <= '0;
            s_sig        <= '0;
            cnt          <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= b;
                        busy   <= 1'b1;
                        done_2 <= 1'b0;
                        state  <= S_SWAP;
                    end
                end
                S_SWAP: begin
                    l_sign <= l_sign_c;
                    s_sign <= s_sign_c;
                    l_exp  <= l_exp_c;
                    l_sig  <= l_sig_c;
                    // Held internally; the special output only moves on the ADD edge.
                    spec_r <= spec_a | spec_b;
                    if (exp_diff >= 8'd24) begin
                        // Everything would shift out anyway; skip the shift cycles.
                        s_sig <= '0;
                        cnt   <= '0;
                        state <= S_ADD;
                    end else begin
                        s_sig <= s_sig_c;
                        cnt   <= exp_diff[4:0];
                        state <= (exp_diff == '0) ? S_ADD : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Truncating shift: bits falling off the bottom are lost.
                    s_sig <= s_sig >> 1;
                    cnt   <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    mantissa_sum <= sum_c;
                    new_exponent <= l_exp + 8'd1;
                    sign_out     <= (sum_c == '0) ? 1'b0 : l_sign;
                    zero         <= (sum_c == '0);
                    special      <= spec_r;
                    busy         <= 1'b0;
                    done_2       <= 1'b1;
                    state        <= S_DONE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_align_add.sv
// Directed bench for fp_align_add: a reference model computes each result from
// the operand fields, a compare process checks the outputs on every cycle
// done_2 is high, and literal expectations pin the model itself.
module tb_fp_align_add;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;

    logic        busy, done_2, sign_out, zero, special;
    logic [24:0] mantissa_sum;
    logic [7:0]  new_exponent;

    always #5 clk = ~clk;

    fp_align_add dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
        .busy(busy), .done_2(done_2), .mantissa_sum(mantissa_sum),
        .new_exponent(new_exponent), .sign_out(sign_out), .zero(zero),
        .special(special)
    );

    int checks = 0;
    int errors = 0;

    // Packed expectation: {mantissa_sum[24:0], new_exponent[7:0], sign, zero, special}
    logic [35:0] exp_q[$];
    logic [35:0] cur_exp;
    bit          cur_valid = 1'b0;
    bit          done_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y);
        int          ex, ey, el, d;
        logic [24:0] mx, my, ml, ms, sum;
        logic        sl, ss, z;
        ex = int'(x[30:23]);
        ey = int'(y[30:23]);
        mx = (ex == 0) ? 25'd0 : {2'b01, x[22:0]};
        my = (ey == 0) ? 25'd0 : {2'b01, y[22:0]};
        if (ex > ey || (ex == ey && mx >= my)) begin
            el = ex; ml = mx; sl = x[31]; ms = my; ss = y[31]; d = ex - ey;
        end else begin
            el = ey; ml = my; sl = y[31]; ms = mx; ss = x[31]; d = ey - ex;
        end
        if (d >= 24) ms = 25'd0;
        else         ms = ms >> d;
        sum = (sl == ss) ? ml + ms : ml - ms;
        z   = (sum == 25'd0);
        return {sum, 8'((el + 1) % 256), z ? 1'b0 : sl, z, (ex == 255 || ey == 255)};
    endfunction

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (rst === 1'b1 && done_2 === 1'b1) begin
            if (!done_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done got=1 want=0");
                    cur_valid = 1'b0;
                end else begin
                    cur_exp   = exp_q.pop_front();
                    cur_valid = 1'b1;
                end
            end
            if (cur_valid)
                check("result", 64'({mantissa_sum, new_exponent, sign_out, zero, special}), 64'(cur_exp));
            done_prev = 1'b1;
        end else begin
            done_prev = 1'b0;
            cur_valid = 1'b0;
        end
    end

    // ---------------- driver ----------------
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                          input int exp_lat, input logic [35:0] lit, input bit repulse);
        int n;
        check("model_pin", 64'(model(op_a, op_b)), 64'(lit));
        exp_q.push_back(model(op_a, op_b));
        @(negedge clk);
        a = op_a; b = op_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 1;
        check("busy_on_accept", 64'(busy), 64'(1));
        check("done_cleared", 64'(done_2), 64'(0));
        while (!done_2 && n < 40) begin
            if (repulse && n == 1) begin
                start = 1'b1; a = 32'h40400000; b = 32'h40400000;
            end
            @(posedge clk); #1;
            start = 1'b0;
            n++;
        end
        check("latency", 64'(n), 64'(exp_lat));
        check("busy_off", 64'(busy), 64'(0));
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done_2), 64'(0));
        check("rst_sum", 64'(mantissa_sum), 64'(0));
        check("rst_exp", 64'(new_exponent), 64'(0));
        check("rst_sign", 64'(sign_out), 64'(0));
        check("rst_zero", 64'(zero), 64'(0));
        check("rst_special", 64'(special), 64'(0));
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        run_op(32'h3F800000, 32'h3F800000, 3,  {25'h1000000, 8'h80, 3'b000}, 1'b0);
        run_op(32'h3F800000, 32'h3F000000, 4,  {25'h0C00000, 8'h80, 3'b000}, 1'b0);
        run_op(32'hC0000000, 32'h3F800000, 4,  {25'h0400000, 8'h81, 3'b100}, 1'b0);
        run_op(32'h3F800000, 32'h30800000, 3,  {25'h0800000, 8'h80, 3'b000}, 1'b0);
        run_op(32'h3F800000, 32'hBF800000, 3,  {25'h0000000, 8'h80, 3'b010}, 1'b1);
        run_op(32'h3F800000, 32'h34000000, 26, {25'h0800001, 8'h80, 3'b000}, 1'b0);
        run_op(32'h3F800000, 32'h33800000, 3,  {25'h0800000, 8'h80, 3'b000}, 1'b0);
        run_op(32'h3F000000, 32'hBF800000, 4,  {25'h0400000, 8'h80, 3'b100}, 1'b0);
        run_op(32'h00000001, 32'h3F800000, 3,  {25'h0800000, 8'h80, 3'b000}, 1'b0);

        // Reset in the middle of a SHIFT sequence discards the operation.
        @(negedge clk);
        a = 32'h3F800000; b = 32'h3E000000; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 64'(busy), 64'(1));
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done_2), 64'(0));
        check("midrst_out", 64'({mantissa_sum, new_exponent, sign_out, zero, special}), 64'(0));
        rst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_stays_idle", 64'(done_2), 64'(0));
        run_op(32'h3F800000, 32'h3E000000, 6, {25'h0900000, 8'h80, 3'b000}, 1'b0);
        check("direct_sum", 64'(mantissa_sum), 64'(25'h0900000));

        run_op(32'h7F800000, 32'h3F800000, 3, {25'h0800000, 8'h00, 3'b001}, 1'b0);
        check("direct_special", 64'(special), 64'(1));

        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
